// File: rtl/part_cmd_pkg.sv
// ---------------------------------------------------------------------------
// part_cmd_pkg : command bytes, ASCII constants and FSM state types for the
//                part tester command engine.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package part_cmd_pkg;

  localparam logic [7:0] CMD_RESET = 8'h72;  // 'r'
  localparam logic [7:0] CMD_SCAN  = 8'h73;  // 's'
  localparam logic [7:0] CMD_GET   = 8'h67;  // 'g'
  localparam logic [7:0] CMD_PIS   = 8'h69;  // 'i'
  localparam logic [7:0] CMD_POS   = 8'h6F;  // 'o'
  localparam logic [7:0] CMD_EXEC  = 8'h65;  // 'e'
  localparam logic [7:0] CMD_FREE  = 8'h66;  // 'f'
  localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_1   = 8'h31;
  localparam logic [7:0] ASCII_NAK = 8'h3F;

  localparam logic [7:0] BANNER_0  = 8'h6F;  // 'o'
  localparam logic [7:0] BANNER_1  = 8'h6B;  // 'k'
  localparam logic [7:0] BANNER_2  = 8'h0A;  // '\n'

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_RESET,
    ST_BANNER,
    ST_EXEC,
    ST_FREE,
    ST_GET_BIT,
    ST_SET_BIT,
    ST_IN_BIT,
    ST_OUT_BIT,
    ST_TX_WAIT
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_ARM,
    TX_REQ,
    TX_DRAIN
  } tx_state_t;

  function automatic logic [7:0] bit_to_ascii(input logic b);
    return b ? ASCII_1 : ASCII_0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/part_cmd_tx.sv
// ---------------------------------------------------------------------------
// part_cmd_tx : one-byte send handshake towards uart_tx; done pulses once the
//               transmitter has taken the byte and returned to idle.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module part_cmd_tx
  import part_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       send,
  input  logic [7:0] send_byte,
  output logic       done,
  input  logic       tx_ready,
  output logic       tx_start,
  output logic [7:0] tx_data
);

  tx_state_t  state;
  tx_state_t  state_nx;
  logic [7:0] data_r;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= TX_IDLE;
      data_r <= '0;
    end else begin
      state <= state_nx;
      if (send && (state == TX_IDLE)) begin
        data_r <= send_byte;
      end
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    tx_start = 1'b0;
    case (state)
      TX_IDLE:  if (send) state_nx = TX_ARM;
      TX_ARM:   if (tx_ready) state_nx = TX_REQ;
      TX_REQ: begin
        tx_start = 1'b1;
        if (!tx_ready) state_nx = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (tx_ready) begin
          done     = 1'b1;
          state_nx = TX_IDLE;
        end
      end
      default:  state_nx = TX_IDLE;
    endcase
  end

  assign tx_data = data_r;

endmodule

`default_nettype wire

// File: rtl/part_cmd_engine.sv
// ---------------------------------------------------------------------------
// part_cmd_engine : ASCII command processor driving part clock, reset, scan
//                   and PI pins. Define PART_CMD_NAK_EN to answer bad bytes '?'.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module part_cmd_engine
  import part_cmd_pkg::*;
#(
  parameter int NPIS       = 14,
  parameter int NPOS       = 11,
  parameter int RST_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            tx_start,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            part_clk_en,
  output logic            part_rstn,
  output logic            scan_en,
  output logic            scan_in,
  input  logic            scan_out,
  output logic [NPIS-1:0] pis_o,
  input  logic [NPOS-1:0] pos_i,
  output logic            busy
);

  state_t          state, state_nx;
  state_t          ret, ret_nx;
  logic [7:0]      cmd, cmd_nx;
  logic [15:0]     len, len_nx;
  logic [15:0]     idx, idx_nx;
  logic            pend, pend_nx;
  logic            scan_in_nx;
  logic [NPIS-1:0] pis_nx;
  logic            send;
  logic [7:0]      send_byte;
  logic            tx_done;
  logic            clk_en;
  logic            last;
  logic            pos_bit;
  logic            rx_one;
  logic [15:0]     rx_len;

  assign last   = (idx == len - 16'd1);
  assign rx_one = (rx_data == ASCII_1);
  assign rx_len = {len[15:8], rx_data};

`ifdef PART_CMD_NAK_EN
  logic rx_bad;
  assign rx_bad = (rx_data != ASCII_0) && (rx_data != ASCII_1);
`endif

  always_comb begin
    pos_bit = 1'b0;
    for (int k = 0; k < NPOS; k++) begin
      if (idx == 16'(k)) pos_bit = pos_i[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_RESET;
      ret     <= ST_IDLE;
      cmd     <= '0;
      len     <= '0;
      idx     <= '0;
      pend    <= 1'b0;
      scan_in <= 1'b0;
      pis_o   <= '0;
    end else begin
      state   <= state_nx;
      ret     <= ret_nx;
      cmd     <= cmd_nx;
      len     <= len_nx;
      idx     <= idx_nx;
      pend    <= pend_nx;
      scan_in <= scan_in_nx;
      pis_o   <= pis_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ret_nx     = ret;
    cmd_nx     = cmd;
    len_nx     = len;
    idx_nx     = idx;
    pend_nx    = pend;
    scan_in_nx = scan_in;
    pis_nx     = pis_o;
    send       = 1'b0;
    send_byte  = '0;
    clk_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_EXEC, CMD_GET, CMD_SCAN, CMD_PIS, CMD_POS: begin
              cmd_nx   = rx_data;
              state_nx = ST_LEN_HI;
            end
            CMD_RESET: begin
              idx_nx   = '0;
              state_nx = ST_RESET;
            end
            CMD_FREE:  state_nx = ST_FREE;
            CMD_PAUSE: state_nx = ST_IDLE;
            default: begin
`ifdef PART_CMD_NAK_EN
              send      = 1'b1;
              send_byte = ASCII_NAK;
              ret_nx    = ST_IDLE;
              state_nx  = ST_TX_WAIT;
`endif
            end
          endcase
        end
      end
      ST_LEN_HI: begin
        if (rx_valid) begin
          len_nx[15:8] = rx_data;
          state_nx     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (rx_valid) begin
          len_nx  = rx_len;
          idx_nx  = '0;
          pend_nx = 1'b0;
          if (rx_len == 16'd0) begin
            state_nx = ST_IDLE;
          end else begin
            case (cmd)
              CMD_EXEC: state_nx = ST_EXEC;
              CMD_GET:  state_nx = ST_GET_BIT;
              CMD_SCAN: state_nx = ST_SET_BIT;
              CMD_PIS:  state_nx = ST_IN_BIT;
              CMD_POS:  state_nx = ST_OUT_BIT;
              default:  state_nx = ST_IDLE;
            endcase
          end
        end
      end
      ST_RESET: begin
        pis_nx = '0;
        idx_nx = idx + 16'd1;
        if (idx == 16'(RST_CYCLES - 1)) begin
          idx_nx   = '0;
          state_nx = ST_BANNER;
        end
      end
      ST_BANNER: begin
        send = 1'b1;
        case (idx)
          16'd0:   send_byte = BANNER_0;
          16'd1:   send_byte = BANNER_1;
          default: send_byte = BANNER_2;
        endcase
        idx_nx   = idx + 16'd1;
        ret_nx   = (idx == 16'd2) ? ST_IDLE : ST_BANNER;
        state_nx = ST_TX_WAIT;
      end
      ST_EXEC: begin
        clk_en = 1'b1;
        idx_nx = idx + 16'd1;
        if (last) state_nx = ST_IDLE;
      end
      ST_FREE: begin
        clk_en = 1'b1;
        if (rx_valid && (rx_data == CMD_PAUSE)) state_nx = ST_IDLE;
      end
      // pend marks the clock pulse owed after each serviced bit
      ST_GET_BIT: begin
        if (pend) begin
          clk_en  = 1'b1;
          pend_nx = 1'b0;
          idx_nx  = idx + 16'd1;
          if (last) state_nx = ST_IDLE;
        end else begin
          send      = 1'b1;
          send_byte = bit_to_ascii(scan_out);
          pend_nx   = 1'b1;
          ret_nx    = ST_GET_BIT;
          state_nx  = ST_TX_WAIT;
        end
      end
      ST_SET_BIT: begin
        if (pend) begin
          clk_en  = 1'b1;
          pend_nx = 1'b0;
          idx_nx  = idx + 16'd1;
          if (last) state_nx = ST_IDLE;
        end else if (rx_valid) begin
          scan_in_nx = rx_one;
          pend_nx    = 1'b1;
`ifdef PART_CMD_NAK_EN
          if (rx_bad) begin
            send      = 1'b1;
            send_byte = ASCII_NAK;
            ret_nx    = ST_SET_BIT;
            state_nx  = ST_TX_WAIT;
          end
`endif
        end
      end
      ST_IN_BIT: begin
        if (rx_valid) begin
          for (int k = 0; k < NPIS; k++) begin
            if (idx == 16'(k)) pis_nx[k] = rx_one;
          end
          idx_nx = idx + 16'd1;
          if (last) state_nx = ST_IDLE;
`ifdef PART_CMD_NAK_EN
          if (rx_bad) begin
            send      = 1'b1;
            send_byte = ASCII_NAK;
            ret_nx    = last ? ST_IDLE : ST_IN_BIT;
            state_nx  = ST_TX_WAIT;
          end
`endif
        end
      end
      ST_OUT_BIT: begin
        send      = 1'b1;
        send_byte = bit_to_ascii(pos_bit);
        idx_nx    = idx + 16'd1;
        ret_nx    = last ? ST_IDLE : ST_OUT_BIT;
        state_nx  = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (tx_done) state_nx = ret;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign part_clk_en = clk_en;
  assign part_rstn   = (state != ST_RESET);
  assign busy        = (state != ST_IDLE);
  assign scan_en     = (state == ST_GET_BIT) || (state == ST_SET_BIT) ||
                       ((state == ST_TX_WAIT) &&
                        ((ret == ST_GET_BIT) || (ret == ST_SET_BIT)));

  part_cmd_tx u_tx (
    .clk       (clk),
    .rstn      (rstn),
    .send      (send),
    .send_byte (send_byte),
    .done      (tx_done),
    .tx_ready  (tx_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_part_cmd_engine.sv
// ---------------------------------------------------------------------------
// tb_part_cmd_engine : directed stimulus with a tx byte scoreboard for
//                      part_cmd_engine (PART_CMD_NAK_EN adds '?' cases).
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_part_cmd_engine;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic        part_clk_en;
  logic        part_rstn;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out = 1'b0;
  logic [13:0] pis_o;
  logic [10:0] pos_i;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;
  int          rst_low = 0;
  int          tx_cnt = 0;
  logic [3:0]  chain = 4'b0000;
  logic [7:0]  exp_q[$];

  part_cmd_engine #(.NPIS(14), .NPOS(11), .RST_CYCLES(4)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .part_clk_en (part_clk_en),
    .part_rstn   (part_rstn),
    .scan_en     (scan_en),
    .scan_in     (scan_in),
    .scan_out    (scan_out),
    .pis_o       (pis_o),
    .pos_i       (pos_i),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // uart_tx model + tx scoreboard monitor, part clock/reset counters, 4-bit scan chain
  always @(negedge clk) begin
    if (!rstn) begin
      tx_ready = 1'b1;
      tx_cnt   = 0;
    end else begin
      if (tx_ready && tx_start) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%02h required=none", tx_data);
        end else begin
          check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        tx_ready = 1'b0;
        tx_cnt   = 3;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_ready = 1'b1;
      end
      if (part_clk_en) pulse_cnt++;
      if (!part_rstn) rst_low++;
      if (part_clk_en && scan_en) chain = {chain[2:0], scan_in};
    end
    scan_out = chain[3];
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cmd3(input logic [7:0] c, input logic [15:0] n);
    send_byte(c);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while ((busy || !tx_ready) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic push_ok();
    exp_q.push_back(8'h6F);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h0A);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] o_exp [12];
    o_exp = '{8'h31, 8'h30, 8'h30, 8'h31, 8'h30, 8'h31,
              8'h30, 8'h31, 8'h31, 8'h31, 8'h31, 8'h30};
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pos_i    = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_part_clk_en", {31'd0, part_clk_en}, 32'd0);
    check("rst_part_rstn", {31'd0, part_rstn}, 32'd0);
    check("rst_scan", {30'd0, scan_en, scan_in}, 32'd0);
    check("rst_pis", {18'd0, pis_o}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    push_ok();
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_idle("banner_idle");
    check("powerup_rst_cycles", rst_low, 4);
    check("banner_pending", exp_q.size(), 0);

    pulse_cnt = 0;
    cmd3(8'h65, 16'd4);
    wait_idle("exec4_idle");
    check("exec4_pulses", pulse_cnt, 4);

    pulse_cnt = 0;
    cmd3(8'h65, 16'd0);
    wait_idle("exec0_idle");
    check("exec0_pulses", pulse_cnt, 0);

    pulse_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      rx_valid = (c == 0) || (c == 3) || (c == 6);
      rx_data  = (c == 0) ? 8'h66 : (c == 3) ? 8'h78 : 8'h70;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle("free_idle");
    check("free_pulses", pulse_cnt, 6);

    pulse_cnt = 0;
    cmd3(8'h73, 16'd4);
    send_byte(8'h31);
    send_byte(8'h30);
    send_byte(8'h31);
    send_byte(8'h31);
    wait_idle("scan_set_idle");
    check("scan_set_pulses", pulse_cnt, 4);
    check("scan_chain", {28'd0, chain}, 32'hB);

    exp_q.push_back(8'h31);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h31);
    pulse_cnt = 0;
    cmd3(8'h67, 16'd4);
    wait_idle("scan_get_idle");
    check("scan_get_pulses", pulse_cnt, 4);
    check("scan_get_pending", exp_q.size(), 0);
    check("scan_en_idle", {31'd0, scan_en}, 32'd0);

    cmd3(8'h69, 16'd16);
    for (int k = 0; k < 16; k++) send_byte((k % 2 == 0) ? 8'h31 : 8'h30);
    wait_idle("pis_idle");
    check("pis_value", {18'd0, pis_o}, 32'h1555);

    pos_i = 11'h7A9;
    for (int k = 0; k < 12; k++) exp_q.push_back(o_exp[k]);
    cmd3(8'h6F, 16'd12);
    wait_idle("pos_idle");
    check("pos_pending", exp_q.size(), 0);

    // chain now holds 1111, so every aborted 'g' byte is '1'
    for (int k = 0; k < 4; k++) exp_q.push_back(8'h31);
    cmd3(8'h67, 16'd4);
    repeat (20) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_part_rstn", {31'd0, part_rstn}, 32'd0);
    check("abort_pis", {18'd0, pis_o}, 32'd0);
    exp_q.delete();
    push_ok();
    rst_low = 0;
    @(posedge clk);
    #1 rstn = 1'b1;
    wait_idle("abort_idle");
    check("abort_rst_cycles", rst_low, 4);
    check("abort_banner_pending", exp_q.size(), 0);

`ifdef PART_CMD_NAK_EN
    exp_q.push_back(8'h3F);
    send_byte(8'h78);
    wait_idle("nak_cmd_idle");
    check("nak_cmd_pending", exp_q.size(), 0);

    exp_q.push_back(8'h3F);
    pulse_cnt = 0;
    cmd3(8'h73, 16'd1);
    send_byte(8'h7A);
    wait_idle("nak_scan_idle");
    check("nak_scan_in", {31'd0, scan_in}, 32'd0);
    check("nak_scan_pulses", pulse_cnt, 1);
    check("nak_scan_pending", exp_q.size(), 0);
`endif

    repeat (10) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/part_cmd_engine.md
# part_cmd_engine

Parametrised, synthesizable command processor for the part tester. It sits between the `uart_rx`/`uart_tx` pair and the part under test. It decodes the single-byte ASCII command set (`r s g i o e f p`) with 16-bit length/cycle operands, and drives the part's clock enable, reset, scan and primary-input pins. Unlike the fixed-width control path it replaces, PI/PO widths and reset length are parameters, and scan shifting is bit-serial for any chain length up to 65535.

## Interface
- `NPIS`, default 14: number of part primary inputs driven.
- `NPOS`, default 11: number of part primary outputs sampled.
- `RST_CYCLES`, default 4: clocks `part_rstn` is held low by `r`.
- `clk` in 1: system clock; all logic is on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid.
- `rx_data` in 8: received byte.
- `tx_start` out 1: transmit request to `uart_tx`.
- `tx_data` out 8: byte to transmit; stable while `tx_start` is high.
- `tx_ready` in 1: transmitter idle.
- `part_clk_en` out 1: gates the part clock for one `clk` per asserted cycle.
- `part_rstn` out 1: part reset, active low.
- `scan_en` out 1: scan enable (`test_se`).
- `scan_in` out 1: scan chain serial input.
- `scan_out` in 1: scan chain serial output.
- `pis_o` out NPIS: part primary inputs.
- `pos_i` in NPOS: part primary outputs.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LEN_HI, LEN_LO, RESET, BANNER, EXEC, FREE, GET_BIT, SET_BIT, IN_BIT, OUT_BIT, TX_WAIT.
- IDLE: on `rx_valid` the byte is decoded.
  - `e g s i o` latch the command and go to LEN_HI → LEN_LO, which collect `N` = {hi, lo}.
  - `r` goes to RESET. `f` goes to FREE.
  - Any other byte, including `p`, is dropped.
- `r`: `part_rstn`=0 for RST_CYCLES clocks. `pis_o` is cleared. BANNER then transmits "ok\n" (0x6F 0x6B 0x0A).
- `e N`: `part_clk_en`=1 for exactly N clocks. N=0 returns to IDLE with no pulse.
- `f`: `part_clk_en`=1 every clock until a `p` byte arrives. Other bytes are ignored. `part_clk_en` drops the cycle after `p` is strobed.
- `g N`: `scan_en`=1. For each of N bits:
  - Sample `scan_out` and transmit '1' (0x31) or '0' (0x30).
  - After tx completes, pulse `part_clk_en` one clock.
- `s N`: `scan_en`=1. Each received byte drives `scan_in` (bit = `rx_data`==0x31), followed by one `part_clk_en` pulse.
- `i N`: received byte k sets `pis_o[k]`. Bytes with k ≥ NPIS are consumed but discarded.
- `o N`: transmits `pos_i[k]` as ASCII for k = 0..N-1. k ≥ NPOS sends '0'.
- N=0 for `g s i o` returns to IDLE immediately, with no tx and no rx consumed.
- `rx_valid` bytes arriving during `g`, `o`, EXEC and BANNER are dropped.
- Bit index counter is 16 bits and never wraps; N=65535 is legal.

## Timing
- Reset values:
  - `tx_start`=0, `tx_data`=0.
  - `part_clk_en`=0, `part_rstn`=0, `scan_en`=0, `scan_in`=0, `pis_o`=0.
  - `busy`=1. State is RESET, so power-up runs the `r` sequence and banner.
- Tx handshake:
  - `tx_start` rises only when `tx_ready`=1.
  - It is held until `tx_ready`=0 is seen, then dropped.
  - The next byte waits for `tx_ready` to return to 1.
- `part_clk_en` first pulse is the cycle after LEN_LO accepts the low byte.
- `scan_en` asserts with LEN_LO exit and deasserts on return to IDLE.
- Asynchronous `rstn` mid-command aborts the command. Partial `pis_o` writes are lost; the block restarts at RESET.

## Configuration
- `PART_CMD_NAK_EN` defined:
  - An unknown command byte in IDLE transmits '?' (0x3F).
  - In `s`/`i`, a data byte other than 0x30/0x31 transmits '?'. That bit is still consumed as 0.
- Undefined: such bytes are silently dropped or treated as 0; no '?' is ever sent.

## Structure
- Package `part_cmd_pkg`: command byte constants, state enum, ASCII constants '0' '1' '?' and the banner bytes.
- Sub-module `part_cmd_tx`: byte-send handshake FSM with start/done interface, instantiated once.

## Test plan
- Power-up: release `rstn` → `part_rstn` low 4 clocks, then "ok\n" transmitted, then `busy`=0.
- `e` 0x00 0x04 → exactly 4 `part_clk_en` cycles. `e` 0x00 0x00 → none.
- `f`, then `p` after 6 clocks → 6 `part_clk_en` cycles, drop the cycle after `p`; bytes between them ignored.
- `s` len 4 with "1011", chain fed back to `scan_out`, then `g` len 4 → "1011" returned, 4 clock pulses each.
- `i` len 16 with alternating '1'/'0' → `pis_o`=14'b01_0101_0101_0101, extra 2 bytes consumed. `o` len 12 with `pos_i`=0x7A9 → '1','0','0','1','0','1','0','1','1','1','1','0'.
- With `PART_CMD_NAK_EN`: byte 'x' → '?' sent. `s` len 1 with byte 'z' → '?', `scan_in`=0. Assert `rstn` mid-`g` → restarts at RESET.
